// File: rtl/mips_pkg.sv
// Shared types for the MIPS CPU bus fabric.
//   arb_state_t    : bus arbiter state encoding
//   BYTEENABLE_ALL : full-word lane mask
//   arb_pick       : arbitration decision used wherever the arbiter may
//                    hand the bus to a new owner
package mips_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

    // Decide the next bus owner from the current requests.
    // last_d is 1 when the D port was the most recent owner; with round
    // robin enabled the port that did not own the bus last wins a tie,
    // otherwise the D port always wins a tie.
    function automatic arb_state_t arb_pick(
        input logic i_req,
        input logic d_req,
        input logic last_d,
        input logic round_robin
    );
        arb_state_t pick;
        pick = ARB_IDLE;
        if (i_req && d_req) begin
            if (round_robin) begin
                pick = last_d ? ARB_GRANT_I : ARB_GRANT_D;
            end else begin
                pick = ARB_GRANT_D;
            end
        end else if (d_req) begin
            pick = ARB_GRANT_D;
        end else if (i_req) begin
            pick = ARB_GRANT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall watchdog for the shared memory bus.
// Counts consecutive enabled cycles, saturating at MAX_WAIT. The error flag
// is registered on the same edge at which the count reaches MAX_WAIT and
// then stays set until reset, independent of later clears.
// Ports:
//   clk      in  clock
//   reset    in  synchronous, active-high
//   count_en in  a granted transaction is stalled this cycle
//   clear    in  restart the count (clear has priority over count_en)
//   error    out sticky stall error
module bus_watchdog #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic error
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] count;
    logic          error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            error_q <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != MAX_CNT)) begin
            count <= count + ONE;
            if (count == (MAX_CNT - ONE)) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the CPU's single Avalon-MM master bus between the instruction
// fetch port (I, read-only) and the load/store port (D, read/write).
// One requester owns the bus per transaction; ownership is held until the
// memory drops waitrequest, and a watchdog flags transactions stalled for
// MAX_WAIT cycles without aborting them.
//
// Handshake: a requester holds its request (and address/data) stable until
// it sees its own waitrequest low at a rising edge; that edge completes the
// transfer. A port that is not granted always sees waitrequest high, so the
// first request from idle always stalls at least one cycle.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   i_address, i_read                fetch request
//   i_waitrequest, i_readdata        fetch stall / data
//   d_address, d_read, d_write,
//   d_writedata, d_byteenable        load/store request
//   d_waitrequest, d_readdata        load/store stall / data
//   address, read, write,
//   writedata, byteenable            bus master outputs
//   waitrequest, readdata            bus slave responses
//   grant_d                          D port currently owns the bus
//   bus_error                        sticky watchdog flag
module mips_bus_arbiter
    import mips_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned MAX_WAIT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        grant_d,
    output logic        bus_error
);

    arb_state_t state, state_next;
    logic       last_d, last_d_next;

    logic i_req, d_req;
    logic granted, granted_req, done;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    assign granted     = (state != ARB_IDLE);
    assign granted_req = ((state == ARB_GRANT_I) && i_req) ||
                         ((state == ARB_GRANT_D) && d_req);
    assign done        = granted_req && !waitrequest;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB_IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            last_d <= last_d_next;
        end
    end

    // ---------------- next state ----------------
    // A granted port that drops its request without completing forfeits the
    // bus (back to idle); a completing port lets arbitration run again in the
    // same cycle so back-to-back transfers need no idle cycle.
    always_comb begin
        state_next  = state;
        last_d_next = last_d;
        case (state)
            ARB_IDLE: begin
                state_next = arb_pick(i_req, d_req, last_d, ROUND_ROBIN);
            end
            ARB_GRANT_I: begin
                if (!i_req) begin
                    state_next = ARB_IDLE;
                end else if (!waitrequest) begin
                    state_next = arb_pick(i_req, d_req, last_d, ROUND_ROBIN);
                end
            end
            ARB_GRANT_D: begin
                if (!d_req) begin
                    state_next = ARB_IDLE;
                end else if (!waitrequest) begin
                    state_next = arb_pick(i_req, d_req, last_d, ROUND_ROBIN);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        if (state_next == ARB_GRANT_D) begin
            last_d_next = 1'b1;
        end else if (state_next == ARB_GRANT_I) begin
            last_d_next = 1'b0;
        end
    end

    // ---------------- bus mux ----------------
    always_comb begin
        address       = 32'h0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = 32'h0;
        byteenable    = BYTEENABLE_ALL;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        case (state)
            ARB_GRANT_I: begin
                address       = i_address;
                read          = i_read;
                i_waitrequest = waitrequest;
            end
            ARB_GRANT_D: begin
                address       = d_address;
                // A simultaneous read and write request is treated as a write.
                read          = d_read & ~d_write;
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; only the port seeing waitrequest low uses it.
    assign i_readdata = readdata;
    assign d_readdata = readdata;

    assign grant_d = (state == ARB_GRANT_D);

    // ---------------- watchdog ----------------
    bus_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .count_en (granted && waitrequest),
        .clear    (!granted || done),
        .error    (bus_error)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter. Two instances share clock and reset:
// index 0 is round robin, index 1 is fixed D priority; both use MAX_WAIT = 8.
// Inputs are driven and outputs sampled one time unit after the falling
// edge. Completed bus transfers are popped from exp_q and compared.
module tb_mips_bus_arbiter;

  localparam int N   = 2;
  localparam int TXW = 68;  // {grant_d, write, i_waitrequest, d_waitrequest, address, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] i_address       [N];
  logic        i_read          [N];
  logic        i_waitrequest   [N];
  logic [31:0] i_readdata      [N];
  logic [31:0] d_address       [N];
  logic        d_read          [N];
  logic        d_write         [N];
  logic [31:0] d_writedata     [N];
  logic [3:0]  d_byteenable    [N];
  logic        d_waitrequest   [N];
  logic [31:0] d_readdata      [N];
  logic [31:0] bus_address     [N];
  logic        bus_read        [N];
  logic        bus_write       [N];
  logic [31:0] bus_writedata   [N];
  logic [3:0]  bus_byteenable  [N];
  logic        mem_waitrequest [N];
  logic [31:0] mem_readdata    [N];
  logic        grant_d         [N];
  logic        bus_error       [N];

  mips_bus_arbiter #(.ROUND_ROBIN(1'b1), .MAX_WAIT(8)) dut_rr (
    .clk(clk), .reset(reset),
    .i_address(i_address[0]), .i_read(i_read[0]),
    .i_waitrequest(i_waitrequest[0]), .i_readdata(i_readdata[0]),
    .d_address(d_address[0]), .d_read(d_read[0]), .d_write(d_write[0]),
    .d_writedata(d_writedata[0]), .d_byteenable(d_byteenable[0]),
    .d_waitrequest(d_waitrequest[0]), .d_readdata(d_readdata[0]),
    .address(bus_address[0]), .read(bus_read[0]), .write(bus_write[0]),
    .writedata(bus_writedata[0]), .byteenable(bus_byteenable[0]),
    .waitrequest(mem_waitrequest[0]), .readdata(mem_readdata[0]),
    .grant_d(grant_d[0]), .bus_error(bus_error[0])
  );

  mips_bus_arbiter #(.ROUND_ROBIN(1'b0), .MAX_WAIT(8)) dut_fp (
    .clk(clk), .reset(reset),
    .i_address(i_address[1]), .i_read(i_read[1]),
    .i_waitrequest(i_waitrequest[1]), .i_readdata(i_readdata[1]),
    .d_address(d_address[1]), .d_read(d_read[1]), .d_write(d_write[1]),
    .d_writedata(d_writedata[1]), .d_byteenable(d_byteenable[1]),
    .d_waitrequest(d_waitrequest[1]), .d_readdata(d_readdata[1]),
    .address(bus_address[1]), .read(bus_read[1]), .write(bus_write[1]),
    .writedata(bus_writedata[1]), .byteenable(bus_byteenable[1]),
    .waitrequest(mem_waitrequest[1]), .readdata(mem_readdata[1]),
    .grant_d(grant_d[1]), .bus_error(bus_error[1])
  );

  // ---------------- scoreboard state ----------------
  logic [TXW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected completed transfer: owner, direction, requester-side stalls
  // (only the owner sees waitrequest low), address and data.
  function automatic void push_tx(input logic is_d, input logic is_wr,
                                  input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({is_d, is_wr, is_d, ~is_d, addr, data});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs(input int k);
    i_address[k]       = 32'h0;
    i_read[k]          = 1'b0;
    d_address[k]       = 32'h0;
    d_read[k]          = 1'b0;
    d_write[k]         = 1'b0;
    d_writedata[k]     = 32'h0;
    d_byteenable[k]    = 4'h0;
    mem_waitrequest[k] = 1'b0;
    mem_readdata[k]    = 32'h0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < N; k++) idle_inputs(k);
    next_cycle();
    reset = 1'b0;
    exp_q.delete();
    #1;
  endtask

  // If the bus completes a transfer this cycle, pop and compare it.
  task automatic sample(input int k);
    logic [TXW-1:0] obs;
    logic [31:0]    data;
    if ((bus_read[k] || bus_write[k]) && !mem_waitrequest[k]) begin
      data = bus_write[k] ? bus_writedata[k] : (grant_d[k] ? d_readdata[k] : i_readdata[k]);
      obs  = {grant_d[k], bus_write[k], i_waitrequest[k], d_waitrequest[k], bus_address[k], data};
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_extra observed=%0h expected=none", obs);
      end
      if (exp_q.size() > 0) check("sb_tx", obs, exp_q.pop_front());
    end
  endtask

  task automatic run_until_empty(input int k, input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      sample(k);
      next_cycle();
      c++;
    end
    check("sb_drained", exp_q.size(), 0);
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < N; k++) idle_inputs(k);
    next_cycle();
    do_reset();

    // Reset state on both instances.
    for (int k = 0; k < N; k++) begin
      check("reset_state",
            {bus_read[k], bus_write[k], i_waitrequest[k], d_waitrequest[k], grant_d[k],
             bus_error[k], bus_byteenable[k], bus_address[k], bus_writedata[k]},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0});
    end

    // Single fetch with a zero-wait memory.
    i_read[0] = 1'b1;
    i_address[0] = 32'hBFC0_0000;
    mem_readdata[0] = 32'hCAFE_0001;
    #1;
    check("fetch_c1", {bus_read[0], i_waitrequest[0]}, 2'b01);
    push_tx(1'b0, 1'b0, 32'hBFC0_0000, 32'hCAFE_0001);
    next_cycle();
    check("fetch_c2", {bus_read[0], i_waitrequest[0], bus_address[0]}, {1'b1, 1'b0, 32'hBFC0_0000});
    sample(0);
    check("fetch_done", exp_q.size(), 0);
    next_cycle();
    i_read[0] = 1'b0;
    #1;
    next_cycle();
    check("fetch_idle", {bus_read[0], grant_d[0], i_waitrequest[0]}, 3'b001);

    // Round-robin contention: after reset the last owner is I, so D goes
    // first, then ownership alternates every transfer with no idle cycle.
    do_reset();
    i_read[0] = 1'b1;         i_address[0] = 32'h0000_0100;
    d_write[0] = 1'b1;        d_address[0] = 32'h0000_2000;
    d_writedata[0] = 32'h55AA_0000;
    d_byteenable[0] = 4'b0011;
    mem_readdata[0] = 32'h1111_2222;
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) push_tx(1'b1, 1'b1, 32'h0000_2000, 32'h55AA_0000);
      else            push_tx(1'b0, 1'b0, 32'h0000_0100, 32'h1111_2222);
    end
    #1;
    check("rr_first_stall", {bus_read[0], bus_write[0]}, 2'b00);
    next_cycle();
    for (int t = 0; t < 6; t++) begin
      check("rr_busy", bus_read[0] | bus_write[0], 1'b1);
      check("rr_lanes", bus_byteenable[0], (t % 2 == 0) ? 4'b0011 : 4'b1111);
      sample(0);
      next_cycle();
    end
    check("rr_done", exp_q.size(), 0);
    i_read[0] = 1'b0;
    d_write[0] = 1'b0;
    #1;
    next_cycle();
    next_cycle();

    // Fixed priority: D wins every tie (read+write requested, write wins);
    // I is served only once D stops requesting.
    do_reset();
    i_read[1] = 1'b1;         i_address[1] = 32'h0000_0300;
    d_read[1] = 1'b1;         d_write[1] = 1'b1;
    d_address[1] = 32'h0000_0400;
    d_writedata[1] = 32'h0BAD_F00D;
    d_byteenable[1] = 4'b1000;
    mem_readdata[1] = 32'h3333_4444;
    for (int t = 0; t < 4; t++) push_tx(1'b1, 1'b1, 32'h0000_0400, 32'h0BAD_F00D);
    #1;
    next_cycle();
    for (int t = 0; t < 4; t++) begin
      check("fp_dgrant", {grant_d[1], bus_read[1], bus_write[1], i_waitrequest[1]}, 4'b1011);
      sample(1);
      next_cycle();
    end
    d_read[1] = 1'b0;
    d_write[1] = 1'b0;
    push_tx(1'b0, 1'b0, 32'h0000_0300, 32'h3333_4444);
    #1;
    run_until_empty(1, 6);
    i_read[1] = 1'b0;
    #1;
    next_cycle();
    next_cycle();

    // Wait states on a D store while I also requests: bus held stable for
    // four stalls, store completes on the fifth, I follows back-to-back.
    do_reset();
    d_write[0] = 1'b1;        d_address[0] = 32'h0000_1000;
    d_writedata[0] = 32'hDEAD_BEEF;
    d_byteenable[0] = 4'b1111;
    i_read[0] = 1'b1;         i_address[0] = 32'h0000_0200;
    mem_readdata[0] = 32'h0000_0077;
    mem_waitrequest[0] = 1'b1;
    #1;
    check("ws_idle", {bus_write[0], d_waitrequest[0], i_waitrequest[0]}, 3'b011);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      check("ws_stall",
            {bus_write[0], bus_address[0], bus_writedata[0], bus_byteenable[0],
             d_waitrequest[0], i_waitrequest[0], grant_d[0]},
            {1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b1});
      sample(0);
      next_cycle();
    end
    mem_waitrequest[0] = 1'b0;
    push_tx(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    push_tx(1'b0, 1'b0, 32'h0000_0200, 32'h0000_0077);
    #1;
    check("ws_complete", {d_waitrequest[0], i_waitrequest[0]}, 2'b01);
    sample(0);
    next_cycle();
    d_write[0] = 1'b0;
    #1;
    check("ws_i_next", {grant_d[0], bus_read[0]}, 2'b01);
    sample(0);
    check("ws_done", exp_q.size(), 0);
    next_cycle();
    i_read[0] = 1'b0;
    #1;
    next_cycle();

    // Watchdog: bus_error rises once eight stalled cycles have elapsed,
    // the load still completes, and the flag stays set afterwards.
    do_reset();
    d_read[0] = 1'b1;         d_address[0] = 32'h0000_3000;
    d_byteenable[0] = 4'b1100;
    mem_readdata[0] = 32'h0000_ABCD;
    mem_waitrequest[0] = 1'b1;
    #1;
    next_cycle();
    for (int s = 1; s <= 8; s++) begin
      check("wd_before", bus_error[0], 1'b0);
      next_cycle();
    end
    check("wd_set", bus_error[0], 1'b1);
    check("wd_not_aborted", {grant_d[0], bus_read[0]}, 2'b11);
    mem_waitrequest[0] = 1'b0;
    push_tx(1'b1, 1'b0, 32'h0000_3000, 32'h0000_ABCD);
    #1;
    sample(0);
    check("wd_done", exp_q.size(), 0);
    next_cycle();
    d_read[0] = 1'b0;
    #1;
    next_cycle();
    check("wd_sticky", bus_error[0], 1'b1);
    next_cycle();
    next_cycle();
    check("wd_sticky_idle", bus_error[0], 1'b1);

    // Reset during a stalled GRANT_D load abandons it and clears the flag.
    d_read[0] = 1'b1;         d_address[0] = 32'h0000_4000;
    mem_waitrequest[0] = 1'b1;
    #1;
    next_cycle();
    check("rst_pre", {grant_d[0], bus_read[0], bus_error[0]}, 3'b111);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check("rst_mid",
          {bus_read[0], bus_write[0], i_waitrequest[0], d_waitrequest[0], grant_d[0], bus_error[0]},
          6'b001100);
    d_read[0] = 1'b0;
    #1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
